// File: rtl/stepgen_pkg.sv
// Shared definitions for the step profile generator: state encoding, period floor
// default and saturating period arithmetic.
package stepgen_pkg;

  localparam int unsigned T_FLOOR_DEF = 2;
  localparam int unsigned MAX_W       = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEL  = 2'd1,
    ST_CRUISE = 2'd2,
    ST_DECEL  = 2'd3
  } state_e;

  // a - b floored at lo, never wrapping; callers guarantee a >= lo
  function automatic logic [MAX_W-1:0] sat_sub(input logic [MAX_W-1:0] a,
                                              input logic [MAX_W-1:0] b,
                                              input logic [MAX_W-1:0] lo);
    logic [MAX_W-1:0] r;
    if (b >= (a - lo)) r = lo;
    else               r = a - b;
    return r;
  endfunction

  // a + b computed one bit wider and clamped to hi
  function automatic logic [MAX_W-1:0] sat_add(input logic [MAX_W-1:0] a,
                                              input logic [MAX_W-1:0] b,
                                              input logic [MAX_W-1:0] hi);
    logic [MAX_W:0]   s;
    logic [MAX_W-1:0] r;
    s = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, hi}) r = hi;
    else                r = s[MAX_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/step_timer.sv
// Period down-counter with pulse-width compare: drives STEP high for
// min(PULSE_W, period-1) clocks and strobes on the last clock of each period.
module step_timer
  import stepgen_pkg::*;
#(
  parameter int unsigned W       = 32,
  parameter int unsigned PULSE_W = 50
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] period,
  output logic         step,
  output logic         boundary_c
);

  localparam logic [W-1:0] PW  = W'(PULSE_W);
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] period_q;
  logic [W-1:0] elapsed_q;
  logic [W-1:0] high_w;
  logic         running_q;
  logic         step_q;

  always_comb begin
    high_w     = (PW < (period_q - ONE)) ? PW : (period_q - ONE);
    boundary_c = running_q && (elapsed_q == (period_q - ONE));
  end

  // a new period always restarts with STEP high; no reload at a boundary stops the train
  always_ff @(posedge clk) begin
    if (!reset) begin
      period_q  <= '0;
      elapsed_q <= '0;
      running_q <= 1'b0;
      step_q    <= 1'b0;
    end else if (load) begin
      period_q  <= period;
      elapsed_q <= '0;
      running_q <= 1'b1;
      step_q    <= 1'b1;
    end else if (running_q) begin
      if (boundary_c) begin
        running_q <= 1'b0;
        step_q    <= 1'b0;
      end else begin
        elapsed_q <= elapsed_q + ONE;
        step_q    <= ((elapsed_q + ONE) < high_w);
      end
    end
  end

  assign step = step_q;

endmodule

// File: rtl/step_profile_gen.sv
// Trapezoidal step-pulse generator for one axis: accelerate / cruise / decelerate
// profile FSM with ramped abort, driving the step_timer.
module step_profile_gen
  import stepgen_pkg::*;
#(
  parameter int unsigned W       = 32,
  parameter int unsigned PULSE_W = 50,
  parameter int unsigned T_FLOOR = T_FLOOR_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] n_steps,
  input  logic [W-1:0] t0,
  input  logic [W-1:0] tmin,
  input  logic [W-1:0] delta,
  input  logic         dir_in,
  input  logic         abort,
  output logic         step,
  output logic         dir,
  output logic         busy,
  output logic         done,
  output logic         aborted,
  output logic [W-1:0] step_count
);

  localparam logic [W-1:0] FLOOR = W'(T_FLOOR);
  localparam logic [W-1:0] ONE   = W'(1);

  state_e       state_q, state_d;
  logic [W-1:0] t_q, t_d;
  logic [W-1:0] t0e_q, t0e_d;
  logic [W-1:0] tmine_q, tmine_d;
  logic [W-1:0] delta_q, delta_d;
  logic [W-1:0] n_tgt_q, n_tgt_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] n_acc_q, n_acc_d;
  logic         pend_q, pend_d;
  logic         aborted_q, aborted_d;
  logic         done_q, done_d;
  logic         dir_q, dir_d;
  logic         busy_q, busy_d;

  logic [W-1:0] t0e_in, tmin_fl, tmine_in;
  logic [W-1:0] t_up, t_dn, cnt_inc, rem;
  logic         load_c, boundary_c;

  step_timer #(
    .W       (W),
    .PULSE_W (PULSE_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (load_c),
    .period     (t_d),
    .step       (step),
    .boundary_c (boundary_c)
  );

  // Effective periods of the incoming move, and next-period candidates
  always_comb begin
    t0e_in   = (t0 < FLOOR) ? FLOOR : t0;
    tmin_fl  = (tmin < FLOOR) ? FLOOR : tmin;
    tmine_in = (tmin_fl > t0e_in) ? t0e_in : tmin_fl;
    t_up     = W'(sat_add(MAX_W'(t_q), MAX_W'(delta_q), MAX_W'(t0e_q)));
    t_dn     = W'(sat_sub(MAX_W'(t_q), MAX_W'(delta_q), MAX_W'(tmine_q)));
    cnt_inc  = cnt_q + ONE;
    rem      = n_tgt_q - cnt_inc;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      t_q       <= '0;
      t0e_q     <= '0;
      tmine_q   <= '0;
      delta_q   <= '0;
      n_tgt_q   <= '0;
      cnt_q     <= '0;
      n_acc_q   <= '0;
      pend_q    <= 1'b0;
      aborted_q <= 1'b0;
      done_q    <= 1'b0;
      dir_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      t0e_q     <= t0e_d;
      tmine_q   <= tmine_d;
      delta_q   <= delta_d;
      n_tgt_q   <= n_tgt_d;
      cnt_q     <= cnt_d;
      n_acc_q   <= n_acc_d;
      pend_q    <= pend_d;
      aborted_q <= aborted_d;
      done_q    <= done_d;
      dir_q     <= dir_d;
      busy_q    <= busy_d;
    end
  end

  // Profile FSM: all decisions happen at period boundaries except move acceptance
  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    t0e_d     = t0e_q;
    tmine_d   = tmine_q;
    delta_d   = delta_q;
    n_tgt_d   = n_tgt_q;
    cnt_d     = cnt_q;
    n_acc_d   = n_acc_q;
    pend_d    = pend_q;
    aborted_d = aborted_q;
    dir_d     = dir_q;
    done_d    = 1'b0;
    load_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dir_d     = dir_in;
          delta_d   = delta;
          t0e_d     = t0e_in;
          tmine_d   = tmine_in;
          n_tgt_d   = n_steps;
          cnt_d     = '0;
          n_acc_d   = '0;
          aborted_d = 1'b0;
          pend_d    = 1'b0;
          t_d       = t0e_in;
          if (n_steps == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_ACCEL;
            load_c  = 1'b1;
          end
        end
      end
      default: begin
        if ((state_q != ST_DECEL) && abort) pend_d = 1'b1;
        if (boundary_c) begin
          cnt_d = cnt_inc;
          if (rem == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            pend_d  = 1'b0;
          end else if ((state_q != ST_DECEL) && (pend_q || abort)) begin
            // ramped stop: mirror the steps spent accelerating
            n_tgt_d   = cnt_inc + n_acc_q;
            aborted_d = 1'b1;
            pend_d    = 1'b0;
            if (n_acc_q == '0) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_DECEL;
              t_d     = t_up;
              load_c  = 1'b1;
            end
          end else begin
            load_c = 1'b1;
            case (state_q)
              ST_ACCEL: begin
                if (rem <= n_acc_q) begin
                  state_d = ST_DECEL;
                  t_d     = t_up;
                end else begin
                  t_d = t_dn;
                  if (t_dn != t_q) n_acc_d = n_acc_q + ONE;
                  if (t_dn == tmine_q) state_d = ST_CRUISE;
                end
              end
              ST_CRUISE: begin
                if (rem <= n_acc_q) begin
                  state_d = ST_DECEL;
                  t_d     = t_up;
                end
              end
              default: t_d = t_up;
            endcase
          end
        end
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign dir        = dir_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign step_count = cnt_q;

endmodule

// File: tb/tb_step_profile_gen.sv
// Self-checking bench for step_profile_gen: directed and random moves compared
// against a step-level profile model (period list, abort outcome).
module tb_step_profile_gen;

  localparam int unsigned W       = 32;
  localparam int unsigned PULSE_W = 50;
  localparam int unsigned T_FLOOR = 2;

  logic          clk;
  logic          reset;
  logic          start;
  logic [W-1:0]  n_steps;
  logic [W-1:0]  t0;
  logic [W-1:0]  tmin;
  logic [W-1:0]  delta;
  logic          dir_in;
  logic          abort;
  logic          step;
  logic          dir;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [W-1:0]  step_count;

  int n_checks = 0;
  int n_fail   = 0;

  step_profile_gen #(
    .W       (W),
    .PULSE_W (PULSE_W),
    .T_FLOOR (T_FLOOR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .n_steps    (n_steps),
    .t0         (t0),
    .tmin       (tmin),
    .delta      (delta),
    .dir_in     (dir_in),
    .abort      (abort),
    .step       (step),
    .dir        (dir),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .step_count (step_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Step-level reference: list of periods and whether the move ends as an abort.
  // abort_at is the cycle offset (0 = first cycle of the move) of a one-cycle abort.
  task automatic model(input longint n, input longint t0v, input longint tminv,
                       input longint dv, input int abort_at,
                       output longint per[$], output bit ab);
    longint t0e, tmine, t, cnt, nacc, ntgt, s, rem, nt;
    int     phase;  // 0 accelerate, 1 cruise, 2 decelerate
    bit     pend;
    per   = {};
    ab    = 1'b0;
    t0e   = (t0v < T_FLOOR) ? longint'(T_FLOOR) : t0v;
    tmine = (tminv < T_FLOOR) ? longint'(T_FLOOR) : tminv;
    if (tmine > t0e) tmine = t0e;
    if (n == 0) return;
    t = t0e; cnt = 0; nacc = 0; ntgt = n; s = 0; phase = 0; pend = 1'b0;
    while (per.size() < 1000) begin
      per.push_back(t);
      if (phase != 2 && abort_at >= s && abort_at <= s + t - 1) pend = 1'b1;
      s += t;
      cnt++;
      rem = ntgt - cnt;
      if (rem == 0) break;
      if (pend && phase != 2) begin
        ntgt = cnt + nacc;
        ab   = 1'b1;
        pend = 1'b0;
        if (nacc == 0) break;
        phase = 2;
        t = (t + dv > t0e) ? t0e : t + dv;
      end else if (phase == 0) begin
        if (rem <= nacc) begin
          phase = 2;
          t = (t + dv > t0e) ? t0e : t + dv;
        end else begin
          nt = (t - dv < tmine) ? tmine : t - dv;
          if (nt != t) nacc++;
          t = nt;
          if (t == tmine) phase = 1;
        end
      end else if (phase == 1) begin
        if (rem <= nacc) begin
          phase = 2;
          t = (t + dv > t0e) ? t0e : t + dv;
        end
      end else begin
        t = (t + dv > t0e) ? t0e : t + dv;
      end
    end
  endtask

  task automatic run_move(input int n, input longint t0v, input longint tminv,
                          input longint dv, input bit dv_dir, input int abort_at,
                          input bit abort_with_start);
    longint per[$];
    bit     exp_ab;
    longint total;
    int     rises[$];
    int     highs[$];
    int     hcnt, busy_cnt, n_done, done_off, dir_bad;
    bit     prev;
    longint hw;
    model(longint'(n), t0v, tminv, dv, abort_at, per, exp_ab);
    total = 0;
    foreach (per[i]) total += per[i];

    @(negedge clk);
    n_steps = W'(n);
    t0      = W'(t0v);
    tmin    = W'(tminv);
    delta   = W'(dv);
    dir_in  = dv_dir;
    start   = 1'b1;
    abort   = abort_with_start;
    @(posedge clk);
    #1;
    start   = 1'b0;
    n_steps = W'($urandom);
    t0      = W'($urandom);
    dir_in  = ~dv_dir;

    prev = 1'b0; hcnt = 0; busy_cnt = 0; n_done = 0; done_off = -1; dir_bad = 0;
    for (int o = 0; o < int'(total) + 20; o++) begin
      abort = (o == abort_at);
      @(negedge clk);
      if (step && !prev) rises.push_back(o);
      if (step) hcnt++;
      else if (prev) begin
        highs.push_back(hcnt);
        hcnt = 0;
      end
      prev = step;
      if (busy) busy_cnt++;
      if (done) begin
        n_done++;
        if (done_off < 0) done_off = o;
      end
      if (dir !== dv_dir) dir_bad++;
      @(posedge clk);
      #1;
    end
    abort = 1'b0;

    check("pulse_count", rises.size(), per.size());
    for (int i = 0; i < per.size(); i++) begin
      if (i < rises.size()) begin
        if (i == 0) check("first_rise", rises[0], 0);
        else        check("spacing", rises[i] - rises[i-1], per[i-1]);
      end
      if (i < highs.size()) begin
        hw = (per[i] - 1 < PULSE_W) ? per[i] - 1 : longint'(PULSE_W);
        check("high_time", highs[i], hw);
      end
    end
    check("done_offset", done_off, total);
    check("done_pulses", n_done, 1);
    check("busy_cycles", busy_cnt, total);
    check("step_count", step_count, per.size());
    check("aborted", aborted, exp_ab);
    check("dir_stable", dir_bad, 0);
  endtask

  initial begin
    int     rn, rab;
    longint rt0, rtmin, rd;
    int     no_done;
    reset = 1'b0; start = 1'b0; abort = 1'b0; dir_in = 1'b0;
    n_steps = '0; t0 = '0; tmin = '0; delta = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_step", step, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_aborted", aborted, 0);
    check("rst_count", step_count, 0);
    check("rst_dir", dir, 0);
    reset = 1'b1;

    // full trapezoid, triangle, abort mid step 2, empty move
    run_move(10, 100, 60, 10, 1'b1, -1, 1'b0);
    run_move(5, 100, 60, 10, 1'b0, -1, 1'b0);
    run_move(10, 100, 60, 10, 1'b1, 120, 1'b0);
    run_move(0, 100, 60, 10, 1'b1, -1, 1'b0);
    // floor raising and huge delta
    run_move(6, 1, 1, 0, 1'b0, -1, 1'b0);
    run_move(8, 100, 60, 64'hFFFF_FFFF, 1'b1, -1, 1'b0);
    run_move(7, 40, 1, 64'hFFFF_FFFF, 1'b0, -1, 1'b0);
    // abort together with start is ignored; abort in decel is ignored
    run_move(6, 30, 10, 5, 1'b1, -1, 1'b1);
    run_move(5, 100, 60, 10, 1'b0, 300, 1'b0);

    // reset during cruise, then a fresh move
    @(negedge clk);
    n_steps = W'(10); t0 = W'(100); tmin = W'(60); delta = W'(10); dir_in = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (400) @(posedge clk);
    @(negedge clk);
    check("pre_rst_busy", busy, 1);
    reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("mid_rst_step", step, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_count", step_count, 0);
    check("mid_rst_dir", dir, 0);
    no_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy || step) no_done++;
    end
    check("post_rst_quiet", no_done, 0);
    run_move(10, 100, 60, 10, 1'b1, -1, 1'b0);

    for (int k = 0; k < 10; k++) begin
      rn    = int'($urandom_range(0, 12));
      rt0   = longint'($urandom_range(1, 60));
      rtmin = longint'($urandom_range(1, 60));
      case ($urandom_range(0, 3))
        0:       rd = 0;
        3:       rd = 64'hFFFF_FFFF;
        default: rd = longint'($urandom_range(1, 15));
      endcase
      rab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 300)) : -1;
      run_move(rn, rt0, rtmin, rd, 1'($urandom_range(0, 1)), rab, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
